// File: rtl/dwc_pkg.sv
// Shared constants for the depthwise-conv tap stream.
package dwc_pkg;

  localparam int NUM_TAPS  = 9;
  localparam int TAP_IDX_W = 4;
  localparam int LANES     = 16;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = LANES * LANE_W;

  // Tap ordering follows the processing unit's column packing:
  // tap = 3*col + row, so taps 0..2 are column 0, rows 0..2.

  // Loader FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/dwc_wl_fifo.sv
// Small synchronous FIFO holding SRAM read returns until they are emitted.
// Push and pop in the same cycle are allowed, including when full.
module dwc_wl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

  // Pointer and occupancy bookkeeping
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write
  // NOTE: the data array has no reset; occupancy is tracked by count, so stale words are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dwc_weight_loader.sv
// Reads the nine tap words of one channel group from weight SRAM and streams
// them in tap order to the depthwise processing unit. Reads are credit
// limited so the return FIFO can absorb every in-flight word while hold is up.
module dwc_weight_loader #(
  parameter int ADDR_W     = 12,
  parameter int WORD_W     = 128,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err_start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              w_valid,
  output logic [3:0]        w_idx,
  output logic [WORD_W-1:0] w_data
);
  import dwc_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2);

  logic [1:0]           state;
  logic [ADDR_W-1:0]    base_q;
  logic [TAP_IDX_W-1:0] issued;
  logic [TAP_IDX_W-1:0] emitted;
  logic [RD_LAT-1:0]    rd_sr;

  logic              ret_vld;
  logic              pop_now;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [WORD_W-1:0] fifo_rdata;
  logic [WORD_W-1:0] emit_data;
  logic [OCC_W-1:0]  occ;
  logic              credit_ok;
  logic              issue_next;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // A word returns from SRAM when the oldest stage of the latency tracker is set.
  assign ret_vld = rd_sr[RD_LAT-1];

  // Emit whenever a word is available (queued or arriving now) and hold is low.
  // An empty FIFO lets the arriving word bypass straight to the output register.
  assign pop_now   = (state == ST_LOAD) && (!fifo_empty || ret_vld) && !hold;
  assign fifo_push = ret_vld && !(pop_now && fifo_empty);
  assign fifo_pop  = pop_now && !fifo_empty;
  assign emit_data = fifo_empty ? mem_rd_data : fifo_rdata;

  // Credit check: words issued but not yet emitted must fit in the FIFO after this edge.
  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    occ = OCC_W'(fifo_count) + OCC_W'(mem_rd_en);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OCC_W'(rd_sr[i]);
    end
    if (pop_now) occ = occ - OCC_W'(1);
    credit_ok  = (occ < OCC_W'(FIFO_DEPTH));
    issue_next = (state == ST_LOAD) && (issued < TAP_IDX_W'(NUM_TAPS)) && credit_ok;
  end

  dwc_wl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (mem_rd_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Control FSM, read issue, latency tracking and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      issued      <= '0;
      emitted     <= '0;
      rd_sr       <= '0;
      err_start   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      w_valid     <= 1'b0;
      w_idx       <= '0;
      w_data      <= '0;
    end else begin
      err_start <= start && (state != ST_IDLE);
      mem_rd_en <= 1'b0;
      rd_sr     <= (rd_sr << 1) | RD_LAT'(mem_rd_en);
      w_valid   <= pop_now;
      if (pop_now) begin
        w_idx   <= emitted;
        w_data  <= emit_data;
        emitted <= emitted + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            issued      <= TAP_IDX_W'(1);
            emitted     <= '0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= base_addr;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (issue_next) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= base_q + ADDR_W'(issued);
            issued      <= issued + 1'b1;
          end
          if (emitted == TAP_IDX_W'(NUM_TAPS)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
